memctrl_ifetch_port: RTL and testbench

// Memory-controller side responder for instruction-fetch requests from the instruction fetcher.
// It latches a 32-bit fetch address and requests the RAM bus from the memctrl arbiter.

---
 rtl/memctrl_ifetch_port.sv | 115 +++++++++++
 tb/tb_memctrl_ifetch_port.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memctrl_ifetch_port.sv
// Instruction-fetch responder for the memory controller: wins the RAM bus, reads four
// bytes over the 8-bit port and returns them little-endian as one instruction word.
module memctrl_ifetch_port #(
  parameter int ADDR_W = 32,
  parameter int INS_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              enable_from_insfetcher,
  input  logic [ADDR_W-1:0] addr_from_insfetcher,
  output logic              enable_to_insfetcher,
  output logic [INS_W-1:0]  ins_to_insfetcher,
  input  logic              flush,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_a,
  input  logic [7:0]        mem_din
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT_GNT = 2'd1;
  localparam logic [1:0] READ     = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        issue_cnt;
  logic [1:0]        recv_cnt;
  logic [2:0][7:0]   byte_buf;

  // The RAM answers one cycle after the address, so captures trail issues by one edge:
  // the edge that still sees issue_cnt==1 has no byte to take yet.
  // NOTE: every register here is assigned with <= so all updates on an edge see the
  // pre-edge values; blocking assignments would let mem_a and the counters race.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      addr                 <= '0;
      issue_cnt            <= '0;
      recv_cnt             <= '0;
      // NOTE: the byte buffer is only three registers, so it is cleared on reset and
      // flush like any other state rather than treated as an unreset memory.
      byte_buf             <= '0;
      bus_req              <= 1'b0;
      mem_rd_en            <= 1'b0;
      mem_a                <= '0;
      enable_to_insfetcher <= 1'b0;
      ins_to_insfetcher    <= '0;
    end else if (rdy) begin
      if (flush) begin
        state                <= IDLE;
        issue_cnt            <= '0;
        recv_cnt             <= '0;
        byte_buf             <= '0;
        bus_req              <= 1'b0;
        mem_rd_en            <= 1'b0;
        enable_to_insfetcher <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (enable_from_insfetcher) begin
              addr    <= addr_from_insfetcher;
              bus_req <= 1'b1;
              state   <= WAIT_GNT;
            end
          end

          WAIT_GNT: begin
            if (bus_gnt) begin
              mem_a     <= addr;
              mem_rd_en <= 1'b1;
              issue_cnt <= 3'd1;
              recv_cnt  <= 2'd0;
              state     <= READ;
            end
          end

          READ: begin
            if (issue_cnt < 3'd4) begin
              mem_a     <= addr + ADDR_W'(issue_cnt);
              issue_cnt <= issue_cnt + 3'd1;
            end else begin
              mem_rd_en <= 1'b0;
            end

            if (issue_cnt != 3'd1) begin
              case (recv_cnt)
                2'd0: byte_buf[0] <= mem_din;
                2'd1: byte_buf[1] <= mem_din;
                2'd2: byte_buf[2] <= mem_din;
                default: begin
                  ins_to_insfetcher    <= INS_W'({mem_din, byte_buf});
                  enable_to_insfetcher <= 1'b1;
                  bus_req              <= 1'b0;
                  state                <= DONE;
                end
              endcase
              recv_cnt <= recv_cnt + 2'd1;
            end
          end

          DONE: begin
            enable_to_insfetcher <= 1'b0;
            state                <= IDLE;
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_memctrl_ifetch_port.sv
// Randomized scoreboard bench for memctrl_ifetch_port: a byte-addressed RAM model,
// a grant-delaying arbiter model, and word/address monitors fed from expectation queues.
module tb_memctrl_ifetch_port;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic        enable_from_insfetcher;
  logic [31:0] addr_from_insfetcher;
  logic        enable_to_insfetcher;
  logic [31:0] ins_to_insfetcher;
  logic        flush;
  logic        bus_req;
  logic        bus_gnt;
  logic        mem_rd_en;
  logic [31:0] mem_a;
  logic [7:0]  mem_din;

  memctrl_ifetch_port #(.ADDR_W(32), .INS_W(32)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .rdy                    (rdy),
    .enable_from_insfetcher (enable_from_insfetcher),
    .addr_from_insfetcher   (addr_from_insfetcher),
    .enable_to_insfetcher   (enable_to_insfetcher),
    .ins_to_insfetcher      (ins_to_insfetcher),
    .flush                  (flush),
    .bus_req                (bus_req),
    .bus_gnt                (bus_gnt),
    .mem_rd_en              (mem_rd_en),
    .mem_a                  (mem_a),
    .mem_din                (mem_din)
  );

  int tests = 0;
  int fails = 0;
  int gnt_delay = 0;
  int gnt_cnt = 0;

  logic [7:0]  ram_ovr [logic [31:0]];
  logic [31:0] word_q [$];
  logic [31:0] addr_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // RAM contents: explicit overrides, otherwise a fixed function of the address.
  function automatic logic [7:0] ram_byte(input logic [31:0] a);
    if (ram_ovr.exists(a)) return ram_ovr[a];
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
  endfunction

  // Reference: the instruction is the four bytes at a..a+3 (wrapping), lowest byte first.
  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = ram_byte(a + 32'(i));
    return w;
  endfunction

  // RAM stalls with rdy; data for the address of cycle k shows up in cycle k+1.
  always @(posedge clk) begin
    if (rdy && mem_rd_en) mem_din <= ram_byte(mem_a);
  end

  // Arbiter: grants after gnt_delay real (rdy=1) edges and holds until bus_req drops.
  always @(negedge clk) begin
    if (!bus_req) begin
      bus_gnt <= 1'b0;
      gnt_cnt <= 0;
    end else if (gnt_cnt >= gnt_delay) begin
      bus_gnt <= 1'b1;
    end else if (rdy) begin
      gnt_cnt <= gnt_cnt + 1;
    end
  end

  // Word monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && enable_to_insfetcher) begin
      if (word_q.size() == 0) check("unexpected_pulse", 32'd1, 32'd0);
      else check("ins_word", ins_to_insfetcher, word_q.pop_front());
    end
  end

  // Address monitor: each read consumed by the RAM must be the next expected address.
  always @(negedge clk) begin
    if (rst_n && mem_rd_en && !bus_gnt) begin
      fails++;
      $display("FAIL gnt_protocol: got bus_gnt=0 required 1 while mem_rd_en=1");
    end
    if (rst_n && mem_rd_en && rdy && !flush) begin
      if (addr_q.size() == 0) check("unexpected_read", mem_a, 32'hDEAD_BEEF ^ mem_a);
      else check("mem_a_seq", mem_a, addr_q.pop_front());
    end
  end

  // One fetch. d = grant delay, stall of s edges starting at edge st (s=0: none),
  // f = edge index of a flush relative to the request edge (f<0: none).
  task automatic fetch(input logic [31:0] a, input int d, input int st, input int s, input int f);
    bit aborted;
    int exp_lat, n_addr, end_k, lat;
    bit req_held;
    aborted = (f >= 0) && (f <= 6 + d);
    exp_lat = 6 + d + s;
    n_addr  = 4;
    if (aborted) begin
      n_addr = f - (2 + d);
      if (n_addr < 0) n_addr = 0;
      if (n_addr > 4) n_addr = 4;
    end
    for (int i = 0; i < n_addr; i++) addr_q.push_back(a + 32'(i));
    if (!aborted) word_q.push_back(model_word(a));
    end_k = aborted ? f + 2 : exp_lat + 1;

    gnt_delay              = d;
    enable_from_insfetcher = 1'b1;
    addr_from_insfetcher   = a;
    flush                  = (f == 0);
    rdy                    = 1'b1;
    lat                    = -1;
    req_held               = 1'b1;

    for (int k = 0; k <= end_k; k++) begin
      @(posedge clk);
      #1;
      if (enable_to_insfetcher && lat < 0) lat = k;
      if (!aborted && k < exp_lat && !bus_req) req_held = 1'b0;
      if (aborted && k == f) begin
        check("flush_bus_req", {31'd0, bus_req}, 32'd0);
        check("flush_rd_en", {31'd0, mem_rd_en}, 32'd0);
        check("flush_pulse", {31'd0, enable_to_insfetcher}, 32'd0);
      end
      if (!aborted && f >= 0 && k == f)
        check("done_flush_pulse", {31'd0, enable_to_insfetcher}, 32'd0);
      if (enable_to_insfetcher || (f >= 0 && k >= f)) enable_from_insfetcher = 1'b0;
      flush = (f >= 0) && (k + 1 == f);
      rdy   = !(s > 0 && k + 1 >= st && k + 1 < st + s);
    end

    if (aborted) begin
      check("no_pulse_after_flush", 32'(lat), 32'hFFFF_FFFF);
    end else begin
      check("latency", 32'(lat), 32'(exp_lat));
      check("bus_req_held", {31'd0, req_held}, 32'd1);
    end
    enable_from_insfetcher = 1'b0;
    flush                  = 1'b0;
    rdy                    = 1'b1;
  endtask

  // Asynchronous reset between edges while two reads have been consumed.
  task automatic reset_mid_read(input logic [31:0] a);
    gnt_delay = 0;
    addr_q.push_back(a);
    addr_q.push_back(a + 32'd1);
    enable_from_insfetcher = 1'b1;
    addr_from_insfetcher   = a;
    flush                  = 1'b0;
    rdy                    = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      @(posedge clk);
      #1;
      if (enable_to_insfetcher) enable_from_insfetcher = 1'b0;
    end
    enable_from_insfetcher = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("arst_bus_req", {31'd0, bus_req}, 32'd0);
    check("arst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check("arst_mem_a", mem_a, 32'd0);
    check("arst_pulse", {31'd0, enable_to_insfetcher}, 32'd0);
    check("arst_ins", ins_to_insfetcher, 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n                  = 1'b0;
    rdy                    = 1'b1;
    enable_from_insfetcher = 1'b0;
    addr_from_insfetcher   = '0;
    flush                  = 1'b0;
    mem_din                = '0;
    ram_ovr[32'h100] = 8'h13;
    ram_ovr[32'h101] = 8'h05;
    ram_ovr[32'h102] = 8'h00;
    ram_ovr[32'h103] = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    check("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_pulse", {31'd0, enable_to_insfetcher}, 32'd0);
    check("rst_ins", ins_to_insfetcher, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    check("model_0x100", model_word(32'h100), 32'h0000_0513);
    fetch(32'h100, 0, 0, 0, -1);
    fetch(32'h100, 5, 0, 0, -1);
    fetch(32'h100, 0, 0, 0, 5);
    fetch(32'h200, 0, 0, 0, -1);
    fetch(32'h100, 0, 3, 3, -1);
    fetch(32'hFFFF_FFFE, 0, 0, 0, -1);
    reset_mid_read(32'h300);
    fetch(32'h104, 0, 0, 0, -1);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int d, mode;
      a    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
      d    = $urandom_range(0, 3);
      mode = $urandom_range(0, 3);
      if (mode == 2)
        fetch(a, d, $urandom_range(1, 6 + d), $urandom_range(1, 3), -1);
      else if (mode == 3)
        fetch(a, d, 0, 0, $urandom_range(0, 7 + d));
      else
        fetch(a, d, 0, 0, -1);
    end

    repeat (4) @(posedge clk);
    #1;
    check("word_q_drained", 32'(word_q.size()), 32'd0);
    check("addr_q_drained", 32'(addr_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
